// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state encodings and width helper for shared_timer_arbiter
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every DIV cycles
// ports: clk, rst (async, active-high), clr (sync clear, suppresses tick), tick (pulse when pcnt == DIV-1)
module tick_prescaler import timer_pkg::*; #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int PW = clog2(DIV) < 1 ? 1 : clog2(DIV);
  logic [PW-1:0] r_pcnt;
  assign tick = !clr && r_pcnt == PW'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pcnt <= '0;
    else r_pcnt <= (clr || tick) ? '0 : r_pcnt + 1'b1;
endmodule

// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: round-robin arbiter sharing one prescaled one-shot down-counter among NREQ requesters
// ports: clk, rst (async, active-high); req (level requests), delay (per-requester tick counts, CW each),
// cancel (abort current run); grant/done (one-hot 1-cycle pulses), busy (RUN or DONE), owner (last granted index)
module shared_timer_arbiter import timer_pkg::*; #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int DIV  = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CW-1:0]       delay,
  input  logic                     cancel,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   owner
);
  localparam int OW = clog2(NREQ);
  state_t          r_state;
  logic [OW-1:0]   r_owner, r_rr_last, w_pick;
  logic [CW-1:0]   r_tcnt, w_delay;
  logic [NREQ-1:0] r_grant, r_done;
  logic            r_busy, w_tick, w_clr;
  // scan downward so the last hit is the nearest requester after rr_last
  always_comb begin
    w_pick = '0;
    for (int i = NREQ; i >= 1; i--)
      if (req[(int'(r_rr_last) + i) % NREQ]) w_pick = OW'((int'(r_rr_last) + i) % NREQ);
  end
  assign w_delay = delay[w_pick*CW +: CW];
  // prescaler restarts at every grant and on cancel, so each run starts on a fresh tick phase
  assign w_clr = r_state != RUN || cancel;
  tick_prescaler #(.DIV(DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_rr_last <= OW'(NREQ - 1);
      r_tcnt    <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      case (r_state)
        IDLE: if (|req) begin
          r_owner   <= w_pick;
          r_rr_last <= w_pick;
          r_tcnt    <= w_delay;
          r_grant   <= NREQ'(1) << w_pick;
          r_busy    <= 1'b1;
          r_state   <= RUN;
        end
        RUN: if (cancel) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          if (w_tick && r_tcnt != '0) r_tcnt <= r_tcnt - 1'b1;
          if (r_tcnt == '0 || (w_tick && r_tcnt == CW'(1))) begin
            r_state <= DONE;
            r_done  <= NREQ'(1) << r_owner;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign owner = r_owner;
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb_shared_timer_arbiter: table-driven and scoreboard checks of grant order, done latency, cancel and reset
module tb_shared_timer_arbiter;
  localparam int NREQ = 4, CW = 4, DIV = 3;
  logic clk = 1'b0, rst = 1'b1, cancel = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] delay = '0;
  logic [3:0] grant, done;
  logic busy;
  logic [1:0] owner;
  always #5 clk = ~clk;
  shared_timer_arbiter #(.NREQ(NREQ), .CW(CW), .DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .delay  (delay),
    .cancel (cancel),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .owner  (owner)
  );
  typedef struct { logic [3:0] g; int lat; } exp_t;
  typedef struct { logic [3:0] req; logic [15:0] dly; logic [3:0] g; int lat; } vec_t;
  exp_t exp_q[$];
  exp_t cur;
  vec_t tab[7];
  bit active = 0, chk_idle = 0;
  int cyc = 0, g_cyc = 0, d_cyc = -100, n_grant = 0, n_done = 0, n_cmp = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask
  function automatic int idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", 32'(busy), 0);
        chk_idle = 0;
      end
      if (grant != 0) begin
        n_grant++;
        if (exp_q.size() == 0) check("grant_unexpected", 32'(grant), 0);
        else begin
          cur = exp_q.pop_front();
          check("grant", 32'(grant), 32'(cur.g));
          check("owner", 32'(owner), idx(cur.g));
          check("busy_at_grant", 32'(busy), 1);
          check("grant_gap_ok", 32'(cyc - d_cyc >= 2), 1);
          g_cyc = cyc;
          active = 1;
        end
      end
      if (done != 0) begin
        n_done++;
        if (!active || cur.lat < 0) check("done_unexpected", 32'(done), 0);
        else begin
          check("done", 32'(done), 32'(cur.g));
          check("done_latency", cyc - g_cyc, cur.lat);
          check("busy_at_done", 32'(busy), 1);
        end
        active = 0;
        d_cyc = cyc;
        chk_idle = 1;
      end else if (active && cur.lat >= 0 && cyc - g_cyc > cur.lat) begin
        check("done_missing", 32'(done), 32'(cur.g));
        active = 0;
      end
    end
  end
  task automatic wait_cnt(input bit is_done, input int target, input int budget);
    int t = 0;
    while ((is_done ? n_done : n_grant) < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if ((is_done ? n_done : n_grant) < target)
      check(is_done ? "done_timeout" : "grant_timeout", is_done ? n_done : n_grant, target);
  endtask
  task automatic run_one(input logic [3:0] r, input logic [15:0] d, input logic [3:0] g, input int lat);
    int ng, nd;
    @(posedge clk);
    #1;
    req = r;
    delay = d;
    exp_q.push_back('{g, lat});
    ng = n_grant + 1;
    nd = n_done + 1;
    wait_cnt(0, ng, 30);
    req = '0;
    wait_cnt(1, nd, lat + 10);
    repeat (2) @(posedge clk);
  endtask
  initial begin
    int gstart, nd0;
    tab[0] = '{4'b0100, 16'h0300, 4'b0100, 3 * DIV};
    tab[1] = '{4'b0010, 16'h5505, 4'b0010, 1};
    tab[2] = '{4'b1001, 16'h2005, 4'b1000, 2 * DIV};
    tab[3] = '{4'b1001, 16'h2005, 4'b0001, 5 * DIV};
    tab[4] = '{4'b1111, 16'h1111, 4'b0010, 1 * DIV};
    tab[5] = '{4'b0001, 16'h000F, 4'b0001, 15 * DIV};
    tab[6] = '{4'b1000, 16'h1000, 4'b1000, 1 * DIV};
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (tab[k]) run_one(tab[k].req, tab[k].dly, tab[k].g, tab[k].lat);
    @(posedge clk);
    #1;
    req = 4'b1111;
    delay = 16'h1111;
    nd0 = n_done;
    exp_q.push_back('{4'b0001, DIV});
    exp_q.push_back('{4'b0010, DIV});
    exp_q.push_back('{4'b0100, DIV});
    exp_q.push_back('{4'b1000, DIV});
    exp_q.push_back('{4'b0001, DIV});
    wait_cnt(0, n_grant + 1, 30);
    gstart = g_cyc;
    wait_cnt(0, n_grant + 4, 60);
    req = '0;
    wait_cnt(1, nd0 + 5, 30);
    check("b2b_span", d_cyc - gstart, 4 * (DIV + 2) + DIV);
    repeat (10) @(posedge clk);
    check("b2b_done_count", n_done - nd0, 5);
    #1;
    req = 4'b0100;
    delay = 16'h0501;
    exp_q.push_back('{4'b0100, -1});
    wait_cnt(0, n_grant + 1, 30);
    req = 4'b0001;
    exp_q.push_back('{4'b0001, DIV});
    repeat (3) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    check("cancel_busy", 32'(busy), 0);
    check("cancel_no_grant_yet", 32'(grant), 0);
    @(posedge clk);
    #1;
    check("grant_after_cancel", 32'(grant), 4'b0001);
    req = '0;
    wait_cnt(1, n_done + 1, 20);
    repeat (2) @(posedge clk);
    #1;
    req = 4'b0010;
    delay = 16'h00A0;
    exp_q.push_back('{4'b0010, -1});
    wait_cnt(0, n_grant + 1, 30);
    req = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_owner", 32'(owner), 0);
    check("async_rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    req = 4'b1001;
    delay = 16'h1001;
    nd0 = n_done;
    exp_q.push_back('{4'b0001, DIV});
    exp_q.push_back('{4'b1000, DIV});
    wait_cnt(0, n_grant + 1, 30);
    req = 4'b1000;
    wait_cnt(0, n_grant + 1, 30);
    req = '0;
    wait_cnt(1, nd0 + 2, 30);
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
